// File: rtl/add_round_key_16.sv
// AddRoundKey stage for the 16-bit nibble-oriented core: expands a master key into K0..K2
// and XORs accepted words with the selected round key. Optional macro: ARK_KEY_ZEROIZE_EN.
module add_round_key_16 #(
  parameter logic [3:0] RCON1 = 4'h1,
  parameter logic [3:0] RCON2 = 4'h2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [15:0] key_in,
  output logic        key_ready,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] data_in,
  input  logic [1:0]  round_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_round,
  output logic        out_err
`ifdef ARK_KEY_ZEROIZE_EN
  ,
  input  logic        key_zeroize
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXP1  = 2'd1,
    EXP2  = 2'd2,
    READY = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] k0_reg;
  logic [15:0] k1_reg;
  logic [15:0] k2_reg;
  logic        key_ready_reg;
  logic        out_valid_reg;
  logic [15:0] out_data_reg;
  logic [1:0]  out_round_reg;
  logic        out_err_reg;
  logic [15:0] round_key;
  logic        zeroize;
  logic        xfer;

`ifdef ARK_KEY_ZEROIZE_EN
  assign zeroize = key_zeroize;
`else
  assign zeroize = 1'b0;
`endif

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;
      4'h1: y = 4'h4;
      4'h2: y = 4'hD;
      4'h3: y = 4'h1;
      4'h4: y = 4'h2;
      4'h5: y = 4'hF;
      4'h6: y = 4'hB;
      4'h7: y = 4'h8;
      4'h8: y = 4'h3;
      4'h9: y = 4'hA;
      4'hA: y = 4'h6;
      4'hB: y = 4'hC;
      4'hC: y = 4'h5;
      4'hD: y = 4'h9;
      4'hE: y = 4'h0;
      default: y = 4'h7;
    endcase
    return y;
  endfunction

  // One key-schedule step: next round key from the previous one.
  function automatic logic [15:0] expand(input logic [15:0] k, input logic [3:0] rcon);
    logic [3:0] a, b, c, d;
    a = k[15:12] ^ sbox(k[3:0]) ^ rcon;
    b = k[11:8] ^ a;
    c = k[7:4] ^ b;
    d = k[3:0] ^ c;
    return {a, b, c, d};
  endfunction

  always_comb begin
    state_next = state_reg;
    if (zeroize) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, READY: if (key_load) state_next = EXP1;
        EXP1:        state_next = EXP2;
        EXP2:        state_next = READY;
        default:     state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k0_reg        <= '0;
      k1_reg        <= '0;
      k2_reg        <= '0;
      key_ready_reg <= 1'b0;
    end else if (zeroize) begin
      k0_reg        <= '0;
      k1_reg        <= '0;
      k2_reg        <= '0;
      key_ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, READY: begin
          if (key_load) begin
            k0_reg        <= key_in;
            key_ready_reg <= 1'b0;
          end
        end
        EXP1: k1_reg <= expand(k0_reg, RCON1);
        EXP2: begin
          k2_reg        <= expand(k1_reg, RCON2);
          key_ready_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Illegal round selects a zero key so the word passes through unchanged.
  always_comb begin
    round_key = '0;
    case (round_in)
      2'd0:    round_key = k0_reg;
      2'd1:    round_key = k1_reg;
      2'd2:    round_key = k2_reg;
      default: round_key = '0;
    endcase
  end

  assign in_ready = (state_reg == READY) & ~key_load & ~zeroize & (~out_valid_reg | out_ready);
  assign xfer     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_round_reg <= '0;
      out_err_reg   <= 1'b0;
    end else if (zeroize) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= data_in ^ round_key;
      out_round_reg <= round_in;
      out_err_reg   <= (round_in == 2'd3);
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign key_ready = key_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_round = out_round_reg;
  assign out_err   = out_err_reg;

endmodule
